// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
// Shared types and constants for the generic pipeline stage register
// (pipe_stage_reg) and its optional skid buffer (pipe_skid_buf).
//   - hold_mode_e   : behaviour of a stage while held (stall or bubble)
//   - HOLD_*        : hold levels driven by hazard control; a stage holds when
//                     hold_flag >= its level
//   - INST_NOP      : canonical empty-slot encoding (addi x0, x0, 0)
//   - *_pld_t       : packed payload bundles per pipeline boundary; callers
//                     size DATA_W with $bits(<type>)
//   - occ_t/occ_of  : occupancy type and helper shared by top and skid buffer
// ----------------------------------------------------------------------------
package pipe_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_AW     = 5;
    localparam int unsigned HOLD_W_DEF = 3;
    localparam int unsigned OCC_W      = 2;

    // Empty-slot payload; zero-extended or truncated to DATA_W by the stage
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef enum logic {
        HOLD_STALL  = 1'b0,
        HOLD_BUBBLE = 1'b1
    } hold_mode_e;

    typedef logic [HOLD_W_DEF-1:0] hold_lvl_t;

    // Hold levels, ordered from least to most of the pipe held
    localparam hold_lvl_t HOLD_NONE   = 3'd0;
    localparam hold_lvl_t HOLD_PC     = 3'd1;
    localparam hold_lvl_t HOLD_IF_ID  = 3'd2;
    localparam hold_lvl_t HOLD_ID_EX  = 3'd3;
    localparam hold_lvl_t HOLD_EX_MEM = 3'd4;
    localparam hold_lvl_t HOLD_MEM_WB = 3'd5;
    localparam hold_lvl_t HOLD_ALL    = 3'd7;

    typedef logic [OCC_W-1:0] occ_t;

    // IF/ID boundary payload
    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] addr;
    } if_id_pld_t;

    // ID/EX boundary payload
    typedef struct packed {
        logic [XLEN-1:0]   inst;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   op1;
        logic [XLEN-1:0]   op2;
        logic [XLEN-1:0]   offset;
        logic [REG_AW-1:0] rd_addr;
        logic              wen;
    } id_ex_pld_t;

    // EX/MEM boundary payload
    typedef struct packed {
        logic [XLEN-1:0]   inst;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   result;
        logic [XLEN-1:0]   mem_wdata;
        logic [REG_AW-1:0] rd_addr;
        logic              wen;
        logic              mem_req;
        logic              mem_we;
    } ex_mem_pld_t;

    // Number of valid entries given the valid bits of the two slots
    function automatic occ_t occ_of(input logic out_valid, input logic skid_valid);
        return occ_t'(out_valid) + occ_t'(skid_valid);
    endfunction

endpackage : pipe_pkg

// File: rtl/pipe_skid_buf.sv
// ----------------------------------------------------------------------------
// pipe_skid_buf
// Second storage entry of a pipe_stage_reg plus the occupancy and registered
// ready logic. The output register lives in the parent; this block only tells
// the parent whether the skid entry holds data and what it is.
// Ports:
//   clk_i, rst_n_i  clock, async active-low reset
//   i_flush         clear the entry this edge
//   i_hold          stage is held (no input transfer possible)
//   i_bubble        hold is in bubble mode (output slot is being emptied)
//   i_out_valid     output register valid (registered, unmasked)
//   i_out_xfer      output transfer this edge
//   i_in_xfer       input transfer this edge
//   i_in_data       upstream payload
//   o_skid_valid    skid entry holds a payload
//   o_skid_data     skid payload (BUBBLE when empty)
//   o_ready         registered "occupancy < 2" for the current cycle
//   o_occ           valid entries held across both slots
// ----------------------------------------------------------------------------
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int unsigned        DATA_W = 32,
    parameter logic [DATA_W-1:0]  BUBBLE = '0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              i_flush,
    input  logic              i_hold,
    input  logic              i_bubble,
    input  logic              i_out_valid,
    input  logic              i_out_xfer,
    input  logic              i_in_xfer,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_skid_valid,
    output logic [DATA_W-1:0] o_skid_data,
    output logic              o_ready,
    output occ_t              o_occ
);

    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic              r_ready;

    logic              w_skid_valid_nxt;
    logic [DATA_W-1:0] w_skid_data_nxt;
    logic              w_drain;
    occ_t              w_occ;
    occ_t              w_occ_nxt;

    assign w_occ   = occ_of(i_out_valid, r_skid_valid);
    // Output slot is free to refill this edge
    assign w_drain = ~i_out_valid | i_out_xfer;

    // Skid entry next state
    always_comb begin
        w_skid_valid_nxt = r_skid_valid;
        w_skid_data_nxt  = r_skid_data;
        if (i_flush) begin
            w_skid_valid_nxt = 1'b0;
            w_skid_data_nxt  = BUBBLE;
        end else if (i_hold) begin
            // Retained in both hold modes; bubble mode only empties the output
            w_skid_valid_nxt = r_skid_valid;
        end else if (w_drain) begin
            // Skid moves to the output; a new input takes its place. With the
            // skid empty, the input goes straight to the output register.
            if (r_skid_valid) begin
                w_skid_valid_nxt = i_in_xfer;
                w_skid_data_nxt  = i_in_xfer ? i_in_data : BUBBLE;
            end
        end else if (i_in_xfer) begin
            // Output stalled: park the incoming payload
            w_skid_valid_nxt = 1'b1;
            w_skid_data_nxt  = i_in_data;
        end
    end

    // Occupancy after this edge; drives the registered ready
    always_comb begin
        w_occ_nxt = w_occ;
        if (i_flush) begin
            w_occ_nxt = '0;
        end else if (i_hold) begin
            w_occ_nxt = i_bubble ? occ_t'(r_skid_valid) : w_occ;
        end else begin
            w_occ_nxt = w_occ + occ_t'(i_in_xfer) - occ_t'(i_out_xfer);
        end
    end

    // Skid entry and ready registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_skid_valid <= 1'b0;
            r_skid_data  <= BUBBLE;
            r_ready      <= 1'b1;
        end else begin
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_data  <= w_skid_data_nxt;
            r_ready      <= (w_occ_nxt < occ_t'(2));
        end
    end

    assign o_skid_valid = r_skid_valid;
    assign o_skid_data  = r_skid_data;
    assign o_ready      = r_ready;
    assign o_occ        = w_occ;

endmodule : pipe_skid_buf

// File: rtl/pipe_stage_reg.sv
// ----------------------------------------------------------------------------
// pipe_stage_reg
// Generic valid/ready pipeline stage register carrying an opaque DATA_W-bit
// payload, with level-based hold (stall or bubble), flush, and an optional
// 2-entry skid buffer.
// Configuration macro: PIPE_STAGE_SKID_EN
//   defined   -> pipe_skid_buf instantiated, in_ready_o from a flop, occ 0..2
//   undefined -> single register, combinational in_ready_o, occ 0..1
// Ports:
//   clk_i        clock, rising edge
//   rst_n_i      async active-low reset
//   hold_flag_i  hold level from hazard control; held when >= HOLD_LEVEL
//   flush_i      synchronous flush, beats hold
//   in_valid_i   upstream payload valid
//   in_ready_o   stage can accept a payload
//   in_data_i    upstream payload
//   out_valid_o  downstream payload valid (masked during a stall hold)
//   out_ready_i  downstream accepts
//   out_data_o   downstream payload (BUBBLE_VAL when empty)
//   occ_o        valid entries held
// ----------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter logic [31:0] BUBBLE_VAL = INST_NOP,
    parameter int unsigned HOLD_W     = 3,
    parameter int unsigned HOLD_LEVEL = 3,
    parameter int unsigned HOLD_MODE  = 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [HOLD_W-1:0] hold_flag_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occ_o
);

    localparam logic [DATA_W-1:0] BUBBLE = DATA_W'(BUBBLE_VAL);
    localparam hold_mode_e        MODE   = (HOLD_MODE != 0) ? HOLD_BUBBLE : HOLD_STALL;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;

    logic              w_hold;
    logic              w_freeze;
    logic              w_bubble;
    logic              w_out_valid;
    logic              w_out_xfer;
    logic              w_in_ready;
    logic              w_in_xfer;
    logic              w_drain;
    logic              w_skid_valid;
    logic [DATA_W-1:0] w_skid_data;
    occ_t              w_occ;
    logic              w_out_valid_nxt;
    logic [DATA_W-1:0] w_out_data_nxt;

    // Hold decode: stall freezes everything, bubble empties the output slot
    assign w_hold   = (hold_flag_i >= HOLD_W'(HOLD_LEVEL));
    assign w_freeze = w_hold & (MODE == HOLD_STALL);
    assign w_bubble = w_hold & (MODE == HOLD_BUBBLE);

    // A frozen stage must not present its payload, or downstream would
    // consume it while the register keeps it
    assign w_out_valid = r_out_valid & ~w_freeze;
    assign w_out_xfer  = w_out_valid & out_ready_i;
    assign w_in_xfer   = in_valid_i & w_in_ready;
    assign w_drain     = ~r_out_valid | w_out_xfer;

`ifdef PIPE_STAGE_SKID_EN
    logic w_ready_q;

    pipe_skid_buf #(
        .DATA_W (DATA_W),
        .BUBBLE (BUBBLE)
    ) u_skid (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .i_flush      (flush_i),
        .i_hold       (w_hold),
        .i_bubble     (w_bubble),
        .i_out_valid  (r_out_valid),
        .i_out_xfer   (w_out_xfer),
        .i_in_xfer    (w_in_xfer),
        .i_in_data    (in_data_i),
        .o_skid_valid (w_skid_valid),
        .o_skid_data  (w_skid_data),
        .o_ready      (w_ready_q),
        .o_occ        (w_occ)
    );

    // Registered ready, still blocked by this cycle's flush or hold
    assign w_in_ready = w_ready_q & ~w_hold & ~flush_i;
`else
    assign w_skid_valid = 1'b0;
    assign w_skid_data  = BUBBLE;
    assign w_occ        = {1'b0, r_out_valid};
    assign w_in_ready   = ~w_hold & ~flush_i & (~w_out_valid | out_ready_i);
`endif

    // Output register next state: flush > hold > refill/drain
    always_comb begin
        w_out_valid_nxt = r_out_valid;
        w_out_data_nxt  = r_out_data;
        if (flush_i) begin
            w_out_valid_nxt = 1'b0;
            w_out_data_nxt  = BUBBLE;
        end else if (w_freeze) begin
            w_out_valid_nxt = r_out_valid;
        end else if (w_bubble) begin
            w_out_valid_nxt = 1'b0;
            w_out_data_nxt  = BUBBLE;
        end else if (w_drain) begin
            // Oldest payload first: skid before a new input
            if (w_skid_valid) begin
                w_out_valid_nxt = 1'b1;
                w_out_data_nxt  = w_skid_data;
            end else if (w_in_xfer) begin
                w_out_valid_nxt = 1'b1;
                w_out_data_nxt  = in_data_i;
            end else begin
                w_out_valid_nxt = 1'b0;
                w_out_data_nxt  = BUBBLE;
            end
        end
    end

    // Output register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_out_valid <= 1'b0;
            r_out_data  <= BUBBLE;
        end else begin
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
        end
    end

    assign in_ready_o  = w_in_ready;
    assign out_valid_o = w_out_valid;
    assign out_data_o  = r_out_data;
    assign occ_o       = w_occ;

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// ----------------------------------------------------------------------------
// tb_pipe_stage_reg
// Two instances share stimulus: dut (bubble on hold) is tracked every cycle by
// a reference queue model; dut_s (stall on hold) is checked directly in the
// hold and flush scenarios.
// ----------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam logic [31:0] BUB = 32'h0000_0013;
`ifdef PIPE_STAGE_SKID_EN
    localparam int unsigned MAX_OCC = 2;
`else
    localparam int unsigned MAX_OCC = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  hold_flag;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic        in_ready, out_valid;
    logic [31:0] out_data;
    logic [1:0]  occ;
    logic        s_in_ready, s_out_valid;
    logic [31:0] s_out_data;
    logic [1:0]  s_occ;

    int n_chk = 0;
    int n_err = 0;

    // Reference model of dut: queue of payloads held, oldest first
    logic [31:0] q[$];
    logic        m_ov = 1'b0;

    pipe_stage_reg #(
        .DATA_W(32), .BUBBLE_VAL(32'h0000_0013), .HOLD_W(3), .HOLD_LEVEL(3), .HOLD_MODE(1)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .hold_flag_i(hold_flag), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .occ_o(occ)
    );

    pipe_stage_reg #(
        .DATA_W(32), .BUBBLE_VAL(32'h0000_0013), .HOLD_W(3), .HOLD_LEVEL(3), .HOLD_MODE(0)
    ) dut_s (
        .clk_i(clk), .rst_n_i(rst_n), .hold_flag_i(hold_flag), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(s_in_ready), .in_data_i(in_data),
        .out_valid_o(s_out_valid), .out_ready_i(out_ready), .out_data_o(s_out_data),
        .occ_o(s_occ)
    );

    always #5 clk = ~clk;

    // Scoreboard: check state mid-cycle, then apply the coming edge to the model
    always @(negedge clk) begin : mon
        logic hold_m, exp_ready, out_x, in_x, drain;
        if (!rst_n) begin
            q.delete();
            m_ov = 1'b0;
        end
        hold_m = (hold_flag >= 3'd3);
`ifdef PIPE_STAGE_SKID_EN
        exp_ready = !hold_m && !flush && (q.size() < 2);
`else
        exp_ready = !hold_m && !flush && (!m_ov || out_ready);
`endif
        n_chk++;
        if (occ !== 2'(q.size())) begin
            n_err++; $display("FAIL mon_occ @%0t: got %0d want %0d", $time, occ, q.size());
        end
        n_chk++;
        if (out_valid !== m_ov) begin
            n_err++; $display("FAIL mon_out_valid @%0t: got %b want %b", $time, out_valid, m_ov);
        end
        n_chk++;
        if (in_ready !== exp_ready) begin
            n_err++; $display("FAIL mon_in_ready @%0t: got %b want %b", $time, in_ready, exp_ready);
        end
        if (!m_ov) begin
            n_chk++;
            if (out_data !== BUB) begin
                n_err++; $display("FAIL mon_empty_data @%0t: got %h want %h", $time, out_data, BUB);
            end
        end
        if (rst_n) begin
            out_x = m_ov && out_ready;
            in_x  = in_valid && exp_ready;
            if (out_x) begin
                n_chk++;
                if (q.size() == 0) begin
                    n_err++; $display("FAIL mon_data @%0t: got %h want none", $time, out_data);
                end else begin
                    if (out_data !== q[0]) begin
                        n_err++; $display("FAIL mon_data @%0t: got %h want %h", $time, out_data, q[0]);
                    end
                    void'(q.pop_front());
                end
            end
            if (flush) begin
                q.delete();
                m_ov = 1'b0;
            end else if (hold_m) begin
                if (m_ov && !out_x && q.size() > 0) void'(q.pop_front());
                m_ov = 1'b0;
            end else begin
                drain = !m_ov || out_x;
                if (in_x) q.push_back(in_data);
                if (drain) m_ov = (q.size() > 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_drain();
        in_valid = 1'b0; flush = 1'b0; hold_flag = 3'd0; out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; hold_flag = 3'd0; flush = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick(); tick();
        n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_chk++; if (out_data !== BUB) begin n_err++; $display("FAIL reset_data: got %h want %h", out_data, BUB); end
        n_chk++; if (occ !== 2'd0) begin n_err++; $display("FAIL reset_occ: got %0d want 0", occ); end
        n_chk++; if (s_occ !== 2'd0) begin n_err++; $display("FAIL reset_s_occ: got %0d want 0", s_occ); end
        rst_n = 1'b1;
        tick();
        n_chk++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_pass_through();
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_chk++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL pass_valid: got %b want 1", out_valid); end
        n_chk++; if (out_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL pass_data: got %h want deadbeef", out_data); end
        n_chk++; if (occ !== 2'd1) begin n_err++; $display("FAIL pass_occ: got %0d want 1", occ); end
        tick();
        n_chk++; if (occ !== 2'd0) begin n_err++; $display("FAIL pass_drain_occ: got %0d want 0", occ); end
    endtask

`ifdef PIPE_STAGE_SKID_EN
    task automatic test_skid();
        idle_drain();
        in_valid = 1'b1; in_data = 32'h1; tick();
        in_data = 32'h2; tick();
        in_valid = 1'b0;
        n_chk++; if (occ !== 2'd2) begin n_err++; $display("FAIL skid_occ_full: got %0d want 2", occ); end
        n_chk++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL skid_ready_full: got %b want 0", in_ready); end
        n_chk++; if (out_data !== 32'h1) begin n_err++; $display("FAIL skid_head: got %h want 1", out_data); end
        out_ready = 1'b1;
        tick();
        n_chk++; if (out_data !== 32'h2) begin n_err++; $display("FAIL skid_second: got %h want 2", out_data); end
        n_chk++; if (occ !== 2'd1) begin n_err++; $display("FAIL skid_occ_one: got %0d want 1", occ); end
        n_chk++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL skid_ready_back: got %b want 1", in_ready); end
        tick();
        n_chk++; if (occ !== 2'd0) begin n_err++; $display("FAIL skid_occ_empty: got %0d want 0", occ); end
    endtask
`else
    task automatic test_backpressure();
        idle_drain();
        in_valid = 1'b1; in_data = 32'h1; tick();
        in_data = 32'h2; #1;
        n_chk++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_stalled: got %b want 0", in_ready); end
        tick();
        n_chk++; if (out_data !== 32'h1) begin n_err++; $display("FAIL bp_hold_data: got %h want 1", out_data); end
        out_ready = 1'b1; #1;
        n_chk++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_drain: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_chk++; if (out_data !== 32'h2) begin n_err++; $display("FAIL bp_swap_data: got %h want 2", out_data); end
        n_chk++; if (occ !== 2'd1) begin n_err++; $display("FAIL bp_swap_occ: got %0d want 1", occ); end
        tick();
    endtask
`endif

    task automatic test_hold_bubble();
        idle_drain();
        in_valid = 1'b1; in_data = 32'hAAAA_0001; out_ready = 1'b1; hold_flag = 3'd3; #1;
        n_chk++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bub_ready: got %b want 0", in_ready); end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bub_valid%0d: got %b want 0", i, out_valid); end
            n_chk++; if (out_data !== BUB) begin n_err++; $display("FAIL bub_data%0d: got %h want %h", i, out_data, BUB); end
        end
        hold_flag = 3'd2; #1;
        n_chk++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bub_release_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_chk++; if (out_data !== 32'hAAAA_0001) begin n_err++; $display("FAIL bub_resume: got %h want aaaa0001", out_data); end
`ifdef PIPE_STAGE_SKID_EN
        idle_drain();
        in_valid = 1'b1; in_data = 32'hB1; tick();
        in_data = 32'hB2; tick();
        in_valid = 1'b0; hold_flag = 3'd3;
        tick();
        n_chk++; if (occ !== 2'd1) begin n_err++; $display("FAIL bub_skid_kept: got %0d want 1", occ); end
        hold_flag = 3'd0;
        tick();
        n_chk++; if (out_data !== 32'hB2 || out_valid !== 1'b1) begin
            n_err++; $display("FAIL bub_skid_move: got %h/%b want b2/1", out_data, out_valid);
        end
`endif
        idle_drain();
    endtask

    task automatic test_hold_stall();
        idle_drain();
        in_valid = 1'b1; in_data = 32'h0000_CAFE; tick();
        in_valid = 1'b0; hold_flag = 3'd4; #1;
        n_chk++; if (s_in_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready: got %b want 0", s_in_ready); end
        for (int i = 0; i < 3; i++) begin
            n_chk++; if (s_out_valid !== 1'b0) begin n_err++; $display("FAIL stall_valid%0d: got %b want 0", i, s_out_valid); end
            n_chk++; if (s_occ !== 2'd1) begin n_err++; $display("FAIL stall_occ%0d: got %0d want 1", i, s_occ); end
            tick();
        end
        hold_flag = 3'd0; #1;
        n_chk++; if (s_out_valid !== 1'b1 || s_out_data !== 32'h0000_CAFE) begin
            n_err++; $display("FAIL stall_release: got %h/%b want cafe/1", s_out_data, s_out_valid);
        end
        idle_drain();
        n_chk++; if (s_occ !== 2'd0) begin n_err++; $display("FAIL stall_drain: got %0d want 0", s_occ); end
    endtask

    task automatic test_flush();
        idle_drain();
        in_valid = 1'b1; in_data = 32'hF1; tick();
        in_data = 32'hF2; tick();
        in_data = 32'hF3; flush = 1'b1; hold_flag = 3'd7; #1;
        n_chk++; if (occ !== 2'(MAX_OCC)) begin n_err++; $display("FAIL flush_pre_occ: got %0d want %0d", occ, MAX_OCC); end
        n_chk++; if (in_ready !== 1'b0 || s_in_ready !== 1'b0) begin
            n_err++; $display("FAIL flush_ready: got %b/%b want 0/0", in_ready, s_in_ready);
        end
        tick();
        flush = 1'b0; hold_flag = 3'd0; in_valid = 1'b0;
        n_chk++; if (occ !== 2'd0 || out_valid !== 1'b0 || out_data !== BUB) begin
            n_err++; $display("FAIL flush_clear: got occ=%0d v=%b d=%h want 0/0/%h", occ, out_valid, out_data, BUB);
        end
        n_chk++; if (s_occ !== 2'd0 || s_out_valid !== 1'b0 || s_out_data !== BUB) begin
            n_err++; $display("FAIL flush_s_clear: got occ=%0d v=%b d=%h want 0/0/%h", s_occ, s_out_valid, s_out_data, BUB);
        end
        tick();
        n_chk++; if (occ !== 2'd0) begin n_err++; $display("FAIL flush_no_accept: got %0d want 0", occ); end
    endtask

    task automatic test_async_reset();
        idle_drain();
        in_valid = 1'b1; in_data = 32'hE1; tick();
        in_data = 32'hE2; tick();
        #1 rst_n = 1'b0;
        #1;
        n_chk++; if (occ !== 2'd0 || out_valid !== 1'b0 || out_data !== BUB) begin
            n_err++; $display("FAIL areset: got occ=%0d v=%b d=%h want 0/0/%h", occ, out_valid, out_data, BUB);
        end
        n_chk++; if (s_occ !== 2'd0) begin n_err++; $display("FAIL areset_s: got %0d want 0", s_occ); end
        tick();
        rst_n = 1'b1; in_valid = 1'b0; #1;
        n_chk++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL areset_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        int budget;
        for (int i = 0; i < 120; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            hold_flag = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            flush     = ($urandom_range(0, 15) == 0);
            tick();
        end
        in_valid = 1'b0; flush = 1'b0; hold_flag = 3'd0; out_ready = 1'b1;
        budget = 0;
        while (occ !== 2'd0 && budget < 10) begin
            tick();
            budget++;
        end
        n_chk++; if (occ !== 2'd0) begin n_err++; $display("FAIL b2b_drain_timeout: got occ=%0d want 0", occ); end
    endtask

    initial begin
        test_reset();
        test_pass_through();
`ifdef PIPE_STAGE_SKID_EN
        test_skid();
`else
        test_backpressure();
`endif
        test_hold_bubble();
        test_hold_stall();
        test_flush();
        test_async_reset();
        test_back_to_back();
        tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_pipe_stage_reg

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Generic, parametrised pipeline stage register. It is the successor to the fixed per-boundary stage registers (IF/ID, ID/EX, EX/MEM), replacing them with one block. It carries an opaque DATA_W-bit payload and uses a valid/ready handshake. It adds level-based hold, separate flush, a choice between stall and bubble on hold, and an optional 2-entry skid buffer so in_ready_o is a registered signal.

Parameters:
DATA_W, 32, payload width in bits (packed bundle of op1/op2/offset/inst/addr/wen etc.)
BUBBLE_VAL, 32'h0000_0013, payload value for an empty slot (NOP encoding, zero-extended/truncated to DATA_W)
HOLD_W, 3, width of hold_flag_i
HOLD_LEVEL, 3, stage holds when hold_flag_i >= HOLD_LEVEL (unsigned compare)
HOLD_MODE, 1, 0 = STALL (freeze contents), 1 = BUBBLE (inject empty slot into output register)

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  reset, asynchronous, active-low
hold_flag_i  in  HOLD_W  pipeline hold level from hazard control
flush_i  in  1  synchronous flush (branch/trap redirect)
in_valid_i  in  1  upstream payload valid
in_ready_o  out  1  stage can accept the payload
in_data_i  in  DATA_W  upstream payload
out_valid_o  out  1  downstream payload valid
out_ready_i  in  1  downstream accepts the payload
out_data_o  out  DATA_W  downstream payload
occ_o  out  2  number of valid entries held (0..2)

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on rst_n_i. Asserting rst_n_i low clears all state immediately, with no clock edge required.
- Reset values: out_valid_o=0, out_data_o=BUBBLE_VAL, occ_o=0, skid entry empty with data=BUBBLE_VAL. in_ready_o=1 after deassert when skid is enabled; with skid disabled it follows the combinational rule below.
- hold_en = (hold_flag_i >= HOLD_LEVEL).
- Priority, highest first: reset > flush > hold > normal transfer.
- Transfers: an input transfer happens when in_valid_i & in_ready_o at a rising edge; an output transfer when out_valid_o & out_ready_i.
- Latency: 1 cycle when the stage is empty and not held. A payload accepted at edge N appears on out_data_o after edge N with out_valid_o=1.
- Flush: on an edge with flush_i=1, all entries are cleared (valid=0, data=BUBBLE_VAL) and occ becomes 0. in_ready_o=0 during a flush cycle, so any input offered that cycle is not taken. An output transfer coincident with the flush still counts for downstream.
- Hold, STALL mode: all registers are frozen. in_ready_o=0 and out_valid_o is forced to 0 combinationally, so no transfers occur. Contents reappear unchanged when hold drops.
- Hold, BUBBLE mode: the output register loads valid=0, data=BUBBLE_VAL at each held edge, and in_ready_o=0. A valid skid entry is retained; when hold drops it moves to the output register on the next edge.
- Normal operation without skid: in_ready_o = !hold_en & !flush_i & (!out_valid_o | out_ready_i). The output register loads on an input transfer. It clears valid on an output transfer with no simultaneous input.
- Normal operation with skid: in_ready_o is registered and equals (occ < 2) for the next cycle.
  - Input arriving while the output is stalled (out_valid_o & !out_ready_i) goes to the skid entry.
  - When the output drains and skid is valid, skid moves to the output register; if an input transfers on the same edge, it goes to skid.
  - occ_o: +1 per input transfer, -1 per output transfer; a simultaneous in and out transfer leaves it unchanged.
  - Data order is strictly FIFO.
- Boundary conditions:
  - occ=2 makes in_ready_o=0.
  - occ=0 makes out_valid_o=0 and out_data_o=BUBBLE_VAL.
  - Reset asserted mid-transfer discards all payloads.

Optional Feature:
PIPE_STAGE_SKID_EN
- Defined: the 2-entry skid buffer is instantiated; in_ready_o comes from a flop; occ_o ranges 0..2.
- Undefined: single register; in_ready_o follows the combinational rule above; occ_o is 0..1 and bit 1 is tied to 0.

Decomposition:
- Package pipe_pkg holds:
  - hold_mode_e enum (HOLD_STALL, HOLD_BUBBLE);
  - hold level constants (HOLD_PC, HOLD_IF_ID, HOLD_ID_EX, ...);
  - INST_NOP / bubble constant;
  - packed struct typedefs for each boundary payload (id_ex_pld_t etc.) so callers size DATA_W with $bits().
- One sub-module, pipe_skid_buf: the second entry plus the occupancy/ready logic, instantiated only under PIPE_STAGE_SKID_EN.

Test Plan:
- Pass-through (all configurations): in_valid_i=1, in_data_i=32'hDEADBEEF, out_ready_i=1 -> out_valid_o=1, out_data_o=32'hDEADBEEF one cycle later; occ_o=1.
- Skid (PIPE_STAGE_SKID_EN defined): out_ready_i=0, send A=32'h1 then B=32'h2 -> occ_o=2, in_ready_o=0. Then raise out_ready_i -> out_data_o sequence 1, 2; occ_o returns to 0.
- Hold in BUBBLE mode: HOLD_MODE=1, hold_flag_i=3 for 2 cycles with in_valid_i=1 -> out_valid_o=0, out_data_o=32'h13, in_ready_o=0. hold_flag_i=2 -> no hold, transfers resume.
- Hold in STALL mode: HOLD_MODE=0, load 32'hCAFE, assert hold_flag_i=4 for 3 cycles -> out_valid_o=0 while held; after release, out_data_o=32'hCAFE with out_valid_o=1.
- Flush priority: flush_i=1 together with hold_flag_i=7 and occ_o=2 -> next edge occ_o=0, out_valid_o=0, out_data_o=32'h13; the input offered that cycle is not accepted.
- Async reset: assert rst_n_i=0 mid-cycle with occ_o=2 -> outputs reach reset values immediately, with no clock edge required.
